// File: rtl/double_chip_top.sv
// Two-die 3D-stack self-test: ID assignment, power exchange over a 1-bit inter-die
// link, sort, and serial result stream. Optional macro FRAME_PARITY_EN adds frame parity.
module ChipSlice #(
  parameter logic [3:0] PWR = 4'd0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       go_i,
  input  logic       bottom_i,
  input  logic       linkRx_i,
`ifdef FRAME_PARITY_EN
  input  logic       peerErr_i,
  output logic       err_o,
`endif
  output logic       linkTx_o,
  output logic       sortFinish_o,
  output logic [3:0] chipId_o,
  output logic [3:0] pwrUpper_o,
  output logic [3:0] pwrLower_o,
  output logic       dout_o
);

`ifdef FRAME_PARITY_EN
  localparam int FLEN = 6;
`else
  localparam int FLEN = 5;
`endif
  localparam logic [2:0] FRAME_LAST = 3'(FLEN - 1);

  typedef enum logic [2:0] {
    IDLE, UP_ID, UP_PWR, DOWN_PWR, SORT, STREAM, DONE
`ifdef FRAME_PARITY_EN
    , ERR
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      bitCnt_q, bitCnt_d;
  logic            isBottom_q, isBottom_d;
  logic [3:0]      chipId_q, chipId_d;
  logic [3:0]      pwrUpper_q, pwrUpper_d;
  logic [3:0]      pwrLower_q, pwrLower_d;
  logic [FLEN-3:0] rxShift_q, rxShift_d;
  logic [7:0]      sortWord_q, sortWord_d;
  logic            sortFinish_q, sortFinish_d;
  logic            dout_q, dout_d;

  logic [FLEN-2:0] rxWord;
  logic [3:0]      rxData, txData, nbrPwr, nbrId;
  logic [FLEN-1:0] txFrame;
  logic            frameEnd, txActive, ownFirst, rxOk;

  // Both dies step through frames in lockstep, so the receiver knows frame
  // boundaries from its own bit counter; the start bit simply shifts out.
  always_comb begin
    rxWord   = {rxShift_q, linkRx_i};
    frameEnd = (bitCnt_q == FRAME_LAST);
    txData   = (state_q == UP_ID) ? chipId_q : PWR;
    txActive = ((state_q == UP_ID || state_q == UP_PWR) && isBottom_q) ||
               (state_q == DOWN_PWR && !isBottom_q);
`ifdef FRAME_PARITY_EN
    rxData   = rxWord[4:1];
    rxOk     = ~^rxWord;
    txFrame  = {1'b1, txData, ^txData};
`else
    rxData   = rxWord;
    rxOk     = 1'b1;
    txFrame  = {1'b1, txData};
`endif
    linkTx_o = txActive & txFrame[FRAME_LAST - bitCnt_q];
    nbrPwr   = isBottom_q ? pwrUpper_q : pwrLower_q;
    nbrId    = isBottom_q ? chipId_q + 4'd1 : chipId_q - 4'd1;
    ownFirst = (PWR > nbrPwr) || ((PWR == nbrPwr) && (chipId_q < nbrId));
  end

  always_comb begin
    state_d      = state_q;
    bitCnt_d     = bitCnt_q;
    isBottom_d   = isBottom_q;
    chipId_d     = chipId_q;
    pwrUpper_d   = pwrUpper_q;
    pwrLower_d   = pwrLower_q;
    rxShift_d    = {rxShift_q[FLEN-4:0], linkRx_i};
    sortWord_d   = sortWord_q;
    sortFinish_d = sortFinish_q;
    dout_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go_i) begin
          state_d    = UP_ID;
          bitCnt_d   = '0;
          isBottom_d = bottom_i;
          if (bottom_i) chipId_d = 4'd1;
        end
      end
      UP_ID, UP_PWR, DOWN_PWR: begin
        bitCnt_d = bitCnt_q + 3'd1;
        if (frameEnd) begin
          bitCnt_d = '0;
          if (state_q == UP_ID)       state_d = UP_PWR;
          else if (state_q == UP_PWR) state_d = DOWN_PWR;
          else                        state_d = SORT;
          if (state_q == UP_ID && !isBottom_q && rxOk)   chipId_d   = rxData + 4'd1;
          if (state_q == UP_PWR && !isBottom_q && rxOk)  pwrLower_d = rxData;
          if (state_q == DOWN_PWR && isBottom_q && rxOk) pwrUpper_d = rxData;
`ifdef FRAME_PARITY_EN
          if (!txActive && !rxOk) state_d = ERR;
`endif
        end
      end
      SORT: begin
        sortFinish_d = 1'b1;
        sortWord_d   = ownFirst ? {chipId_q, nbrId} : {nbrId, chipId_q};
        bitCnt_d     = '0;
        state_d      = STREAM;
      end
      STREAM: begin
        // Only the bottom die talks to the tester.
        dout_d     = isBottom_q & sortWord_q[7];
        sortWord_d = {sortWord_q[6:0], 1'b0};
        bitCnt_d   = bitCnt_q + 3'd1;
        if (bitCnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        dout_d = 1'b0;
      end
`ifdef FRAME_PARITY_EN
      ERR: begin
        dout_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
`ifdef FRAME_PARITY_EN
    // A link error on either die halts the whole stack.
    if (peerErr_i && state_q != ERR) begin
      state_d      = ERR;
      sortFinish_d = sortFinish_q;
      dout_d       = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      bitCnt_q     <= '0;
      isBottom_q   <= 1'b0;
      chipId_q     <= '0;
      pwrUpper_q   <= '0;
      pwrLower_q   <= '0;
      rxShift_q    <= '0;
      sortWord_q   <= '0;
      sortFinish_q <= 1'b0;
      dout_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bitCnt_q     <= bitCnt_d;
      isBottom_q   <= isBottom_d;
      chipId_q     <= chipId_d;
      pwrUpper_q   <= pwrUpper_d;
      pwrLower_q   <= pwrLower_d;
      rxShift_q    <= rxShift_d;
      sortWord_q   <= sortWord_d;
      sortFinish_q <= sortFinish_d;
      dout_q       <= dout_d;
    end
  end

  assign sortFinish_o = sortFinish_q;
  assign chipId_o     = chipId_q;
  assign pwrUpper_o   = pwrUpper_q;
  assign pwrLower_o   = pwrLower_q;
  assign dout_o       = dout_q;
`ifdef FRAME_PARITY_EN
  assign err_o        = (state_q == ERR);
`endif

endmodule

module double_chip_top #(
  parameter logic [3:0] PWR_0 = 4'd9,
  parameter logic [3:0] PWR_1 = 4'd5
) (
  input  logic       t_clk,
  input  logic       rst_n,
  input  logic       f_layer_0,
  input  logic       f_layer_1,
  output logic       sort_finish_0,
  output logic       sort_finish_1,
  output logic [3:0] chip_id_0,
  output logic [3:0] chip_id_1,
  output logic [3:0] power_value_upper_0,
  output logic [3:0] power_value_upper_1,
  output logic [3:0] power_value_lower_0,
  output logic [3:0] power_value_lower_1,
  output logic       data_out
);

  logic go, tx0, tx1, link, dout0, dout1;
`ifdef FRAME_PARITY_EN
  logic err0, err1;
`endif

  // f_layer_0 wins when both are set, so chip 1 is bottom only without it.
  assign go   = f_layer_0 | f_layer_1;
  assign link = tx0 | tx1;

  ChipSlice #(.PWR(PWR_0)) u_chip0 (
    .clk_i        (t_clk),
    .rst_ni       (rst_n),
    .go_i         (go),
    .bottom_i     (f_layer_0),
    .linkRx_i     (link),
`ifdef FRAME_PARITY_EN
    .peerErr_i    (err1),
    .err_o        (err0),
`endif
    .linkTx_o     (tx0),
    .sortFinish_o (sort_finish_0),
    .chipId_o     (chip_id_0),
    .pwrUpper_o   (power_value_upper_0),
    .pwrLower_o   (power_value_lower_0),
    .dout_o       (dout0)
  );

  ChipSlice #(.PWR(PWR_1)) u_chip1 (
    .clk_i        (t_clk),
    .rst_ni       (rst_n),
    .go_i         (go),
    .bottom_i     (~f_layer_0),
    .linkRx_i     (link),
`ifdef FRAME_PARITY_EN
    .peerErr_i    (err0),
    .err_o        (err1),
`endif
    .linkTx_o     (tx1),
    .sortFinish_o (sort_finish_1),
    .chipId_o     (chip_id_1),
    .pwrUpper_o   (power_value_upper_1),
    .pwrLower_o   (power_value_lower_1),
    .dout_o       (dout1)
  );

  assign data_out = dout0 | dout1;

endmodule

// File: tb/tb_double_chip_top.sv
// Bench for double_chip_top: default-power and tie-power instances checked every
// cycle against a sequence-level model, plus literal checks of the main scenarios.
module tb_double_chip_top;

`ifdef FRAME_PARITY_EN
  localparam int F = 6;
`else
  localparam int F = 5;
`endif

  logic t_clk = 1'b0;
  logic rst_n, f_layer_0, f_layer_1;

  logic       sf0, sf1, dout;
  logic [3:0] id0, id1, up0, up1, lo0, lo1;
  logic       sf0T, sf1T, doutT;
  logic [3:0] id0T, id1T, up0T, up1T, lo0T, lo1T;

  int testsRun = 0;
  int testsFailed = 0;

  bit started = 0;
  int k = 0;
  bit bot0 = 0;
  bit checkEn = 1;
  bit sfEver = 0;
  logic [7:0] stream = '0;
  logic [7:0] streamTie = '0;

  always #5 t_clk = ~t_clk;

  double_chip_top dut (
    .t_clk(t_clk), .rst_n(rst_n), .f_layer_0(f_layer_0), .f_layer_1(f_layer_1),
    .sort_finish_0(sf0), .sort_finish_1(sf1), .chip_id_0(id0), .chip_id_1(id1),
    .power_value_upper_0(up0), .power_value_upper_1(up1),
    .power_value_lower_0(lo0), .power_value_lower_1(lo1), .data_out(dout)
  );

  double_chip_top #(.PWR_0(4'd7), .PWR_1(4'd7)) dutTie (
    .t_clk(t_clk), .rst_n(rst_n), .f_layer_0(f_layer_0), .f_layer_1(f_layer_1),
    .sort_finish_0(sf0T), .sort_finish_1(sf1T), .chip_id_0(id0T), .chip_id_1(id1T),
    .power_value_upper_0(up0T), .power_value_upper_1(up1T),
    .power_value_lower_0(lo0T), .power_value_lower_1(lo1T), .data_out(doutT)
  );

  // Edge counter since E0 and the latched orientation.
  always @(posedge t_clk) begin
    if (!rst_n) begin
      started = 0;
      k = 0;
    end else if (started) begin
      k++;
    end else if (f_layer_0 || f_layer_1) begin
      started = 1;
      k = 0;
      bot0 = f_layer_0;
    end
  end

  function automatic logic [26:0] expectOuts(input logic [3:0] p0, input logic [3:0] p1);
    logic [3:0] pb, pt, idB, idT, loT, upB;
    logic [3:0] e0, e1, eu0, eu1, el0, el1;
    logic [7:0] order;
    logic sf, d;
    int j;
    pb = bot0 ? p0 : p1;
    pt = bot0 ? p1 : p0;
    idB = started ? 4'd1 : 4'd0;
    idT = (started && k >= F) ? 4'd2 : 4'd0;
    loT = (started && k >= 2*F) ? pb : 4'd0;
    upB = (started && k >= 3*F) ? pt : 4'd0;
    sf = started && (k >= 3*F + 1);
    // Bottom has ID 1, so a tie also puts bottom first.
    order = (pb >= pt) ? 8'h12 : 8'h21;
    j = k - (3*F + 2);
    d = (started && j >= 0 && j < 8) ? order[7-j] : 1'b0;
    if (bot0) begin
      e0 = idB; e1 = idT; eu0 = upB; el0 = 4'd0; eu1 = 4'd0; el1 = loT;
    end else begin
      e1 = idB; e0 = idT; eu1 = upB; el1 = 4'd0; eu0 = 4'd0; el0 = loT;
    end
    return {sf, sf, e0, e1, eu0, eu1, el0, el1, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge t_clk) begin
    if (checkEn) begin
      checkOutput("dut outputs vs model",
                  {5'd0, sf0, sf1, id0, id1, up0, up1, lo0, lo1, dout},
                  {5'd0, expectOuts(4'd9, 4'd5)});
      checkOutput("dutTie outputs vs model",
                  {5'd0, sf0T, sf1T, id0T, id1T, up0T, up1T, lo0T, lo1T, doutT},
                  {5'd0, expectOuts(4'd7, 4'd7)});
    end
    if (sf0 || sf1) sfEver = 1;
    if (started && k >= 3*F + 2 && k < 3*F + 10) begin
      stream = {stream[6:0], dout};
      streamTie = {streamTie[6:0], doutT};
    end
  end

  task automatic applyStimulus(input bit f0, input bit f1, input int cycles);
    @(negedge t_clk);
    #2;
    f_layer_0 = f0;
    f_layer_1 = f1;
    repeat (cycles) @(negedge t_clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge t_clk);
    #2;
    rst_n = 1'b0;
    f_layer_0 = 1'b0;
    f_layer_1 = 1'b0;
    repeat (2) @(negedge t_clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic checkScenarioOne(input string tag);
    checkOutput({tag, " chip_id_0"}, 32'(id0), 32'd1);
    checkOutput({tag, " chip_id_1"}, 32'(id1), 32'd2);
    checkOutput({tag, " upper_0"}, 32'(up0), 32'd5);
    checkOutput({tag, " lower_0"}, 32'(lo0), 32'd0);
    checkOutput({tag, " upper_1"}, 32'(up1), 32'd0);
    checkOutput({tag, " lower_1"}, 32'(lo1), 32'd9);
    checkOutput({tag, " sort_finish"}, {30'd0, sf0, sf1}, 32'd3);
    checkOutput({tag, " stream"}, 32'(stream), 32'h12);
    checkOutput({tag, " tie stream"}, 32'(streamTie), 32'h12);
    checkOutput({tag, " data_out after stream"}, 32'(dout), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    f_layer_0 = 1'b0;
    f_layer_1 = 1'b0;
    repeat (3) @(negedge t_clk);
    #1;
    checkOutput("reset outputs", {5'd0, sf0, sf1, id0, id1, up0, up1, lo0, lo1, dout}, 32'd0);

    // Chip 0 at the bottom.
    @(negedge t_clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(1, 0, 3*F + 15);
    checkScenarioOne("bottom0");

    // Chip 1 at the bottom.
    doReset();
    applyStimulus(0, 1, 3*F + 15);
    checkOutput("bottom1 chip_id_1", 32'(id1), 32'd1);
    checkOutput("bottom1 chip_id_0", 32'(id0), 32'd2);
    checkOutput("bottom1 upper_1", 32'(up1), 32'd9);
    checkOutput("bottom1 lower_0", 32'(lo0), 32'd5);
    checkOutput("bottom1 stream", 32'(stream), 32'h21);
    checkOutput("bottom1 tie stream", 32'(streamTie), 32'h12);

    // No first layer ever flagged.
    doReset();
    sfEver = 0;
    applyStimulus(0, 0, 200);
    checkOutput("idle sort_finish seen", 32'(sfEver), 32'd0);
    checkOutput("idle outputs", {5'd0, sf0, sf1, id0, id1, up0, up1, lo0, lo1, dout}, 32'd0);

    // Reset in the middle of the UP_PWR frame.
    doReset();
    applyStimulus(1, 0, F + 3);
    @(negedge t_clk);
    #2;
    rst_n = 1'b0;
    @(negedge t_clk);
    #1;
    checkOutput("midreset outputs", {5'd0, sf0, sf1, id0, id1, up0, up1, lo0, lo1, dout}, 32'd0);
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 0, 3*F + 15);
    checkScenarioOne("after midreset");

    // Random orientation, idle lead-in, post-E0 noise on f_layer and early aborts.
    for (int it = 0; it < 24; it++) begin
      int idle;
      int pat;
      int len;
      doReset();
      idle = $urandom_range(0, 5);
      applyStimulus(0, 0, idle);
      pat = $urandom_range(1, 3);
      applyStimulus(pat[0], pat[1], 1);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3*F) : 3*F + 12;
      for (int c = 0; c < len; c++) begin
        applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      end
    end

`ifdef FRAME_PARITY_EN
    begin
      logic v;
      doReset();
      checkEn = 0;
      applyStimulus(1, 0, F + 2);
      v = dut.link;
      force dut.link = ~v;
      @(negedge t_clk);
      release dut.link;
      repeat (3*F + 15) @(negedge t_clk);
      #1;
      checkOutput("parity sort_finish", {30'd0, sf0, sf1}, 32'd0);
      checkOutput("parity data_out", 32'(dout), 32'd1);
      checkOutput("parity chip_id_1 kept", 32'(id1), 32'd2);
      doReset();
      checkEn = 1;
      applyStimulus(0, 0, 2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
